// File: rtl/reg_operand_fetch.sv
// Register-file operand fetch for the MIPS GPP: takes decoded (rs, rt, rd) requests,
// reads both source registers with same-cycle writeback bypass, and owns the write port.
module reg_operand_fetch #(
  parameter int D_WIDTH  = 32,
  parameter int RA_WIDTH = 5
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RA_WIDTH-1:0] in_rs,
  input  logic [RA_WIDTH-1:0] in_rt,
  input  logic [RA_WIDTH-1:0] in_rd,
  input  logic                in_use_rs,
  input  logic                in_use_rt,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [D_WIDTH-1:0]  out_op_a,
  output logic [D_WIDTH-1:0]  out_op_b,
  output logic [RA_WIDTH-1:0] out_rd,
  input  logic                wb_valid,
  input  logic [RA_WIDTH-1:0] wb_addr,
  input  logic [D_WIDTH-1:0]  wb_data,
  output logic [RA_WIDTH-1:0] R1_Addr,
  output logic [RA_WIDTH-1:0] R2_Addr,
  output logic                R1_en,
  output logic                R2_en,
  input  logic [D_WIDTH-1:0]  R1_Data,
  input  logic [D_WIDTH-1:0]  R2_Data,
  output logic [RA_WIDTH-1:0] W_Addr,
  output logic [D_WIDTH-1:0]  W_Data,
  output logic                W_en
);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;

  state_t state_reg, state_next;

  // Index 0 is source A (port 1), index 1 is source B (port 2).
  logic [1:0][RA_WIDTH-1:0] addr_reg, addr_next;
  logic [1:0]               en_reg, en_next;
  logic [1:0][D_WIDTH-1:0]  op_reg, op_next;
  logic [RA_WIDTH-1:0]      rd_reg, rd_next;

  logic [1:0][D_WIDTH-1:0]  rdata;
  logic [1:0][D_WIDTH-1:0]  op_sel;

  assign rdata[0] = R1_Data;
  assign rdata[1] = R2_Data;

  // The read enable doubles as the "operand used" flag while in READ.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign op_sel[gi] = (!en_reg[gi] || addr_reg[gi] == '0)             ? '0 :
                          (wb_valid && wb_addr == addr_reg[gi])           ? wb_data :
                                                                            rdata[gi];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    en_next    = en_reg;
    op_next    = op_reg;
    rd_next    = rd_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          addr_next  = {in_rt, in_rs};
          en_next    = {in_use_rt, in_use_rs};
          rd_next    = in_rd;
          state_next = READ;
        end
      end
      READ: begin
        op_next    = op_sel;
        en_next    = '0;
        state_next = HOLD;
      end
      HOLD: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      en_reg    <= '0;
      op_reg    <= '0;
      rd_reg    <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      en_reg    <= en_next;
      op_reg    <= op_next;
      rd_reg    <= rd_next;
    end
  end

  assign in_ready  = (state_reg == IDLE) && !Rst;
  assign out_valid = (state_reg == HOLD);
  assign out_op_a  = op_reg[0];
  assign out_op_b  = op_reg[1];
  assign out_rd    = rd_reg;
  assign R1_Addr   = addr_reg[0];
  assign R2_Addr   = addr_reg[1];
  assign R1_en     = en_reg[0];
  assign R2_en     = en_reg[1];

  // $0 is hardwired to zero, so writes to it never reach the register file.
  assign W_Addr = wb_addr;
  assign W_Data = wb_data;
  assign W_en   = wb_valid && (wb_addr != '0) && !Rst;

endmodule

// File: tb/tb_reg_operand_fetch.sv
// Bench for reg_operand_fetch: behavioural register file plus an architectural
// register model; random and directed fetches checked against the model.
module tb_reg_operand_fetch;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          in_valid, in_ready;
  logic [AW-1:0] in_rs, in_rt, in_rd;
  logic          in_use_rs, in_use_rt;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_op_a, out_op_b;
  logic [AW-1:0] out_rd;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic [AW-1:0] R1_Addr, R2_Addr, W_Addr;
  logic          R1_en, R2_en, W_en;
  logic [DW-1:0] R1_Data, R2_Data, W_Data;

  always #5 Clk = ~Clk;

  reg_operand_fetch #(.D_WIDTH(DW), .RA_WIDTH(AW)) dut (
    .Clk(Clk), .Rst(Rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_use_rs(in_use_rs), .in_use_rt(in_use_rt),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rd(out_rd),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .R1_Addr(R1_Addr), .R2_Addr(R2_Addr), .R1_en(R1_en), .R2_en(R2_en),
    .R1_Data(R1_Data), .R2_Data(R2_Data),
    .W_Addr(W_Addr), .W_Data(W_Data), .W_en(W_en)
  );

  // Environment register file; entry 0 holds junk so forced-zero reads are visible.
  logic [DW-1:0] rf   [32];
  logic [DW-1:0] seed [32];
  logic          load_rf;
  always @(posedge Clk) begin
    if (load_rf) begin
      for (int i = 0; i < 32; i++) rf[i] <= seed[i];
    end else if (W_en) begin
      rf[W_Addr] <= W_Data;
    end
  end
  assign R1_Data = rf[R1_Addr];
  assign R2_Data = rf[R2_Addr];

  // Architectural model: what each register should hold after committed writebacks.
  logic [DW-1:0] ref_regs [32];

  int n_vec  = 0;
  int n_miss = 0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic wb_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wb_valid = 1'b1; wb_addr = a; wb_data = d;
    #1;
    n_vec++;
    if (W_en !== (a != 0)) begin
      n_miss++; $display("FAIL wb_wen addr=%0d: got %b want %b", a, W_en, (a != 0));
    end
    step();
    wb_valid = 1'b0;
    if (a != 0) ref_regs[a] = d;
  endtask

  function automatic logic [DW-1:0] expect_op(input logic [AW-1:0] r, input logic use_r,
                                               input logic bp, input logic [AW-1:0] bpa,
                                               input logic [DW-1:0] bpd);
    if (!use_r || r == 0) return '0;
    if (bp && bpa == r) return bpd;
    return ref_regs[r];
  endfunction

  task automatic fetch(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                       input logic urs, input logic urt, input logic bp,
                       input logic [AW-1:0] bpa, input logic [DW-1:0] bpd, input int stall);
    logic [DW-1:0] ea, eb;
    int w;
    w = 0;
    while (!in_ready && w < 20) begin step(); w++; end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_miss++; $display("FAIL ready_timeout: got %b want 1", in_ready);
    end
    in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rd = rd; in_use_rs = urs; in_use_rt = urt;
    step();
    // READ: garbage on the request side must be ignored
    in_valid = 1'(($urandom)); in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
    wb_valid = bp; wb_addr = bpa; wb_data = bpd;
    #1;
    ea = expect_op(rs, urs, bp, bpa, bpd);
    eb = expect_op(rt, urt, bp, bpa, bpd);
    n_vec++;
    if ({in_ready, out_valid, R1_en, R2_en} !== {1'b0, 1'b0, urs, urt}) begin
      n_miss++; $display("FAIL read_ctl: got rdy/ov/en1/en2=%b want %b",
                         {in_ready, out_valid, R1_en, R2_en}, {1'b0, 1'b0, urs, urt});
    end
    n_vec++;
    if ((urs && R1_Addr !== rs) || (urt && R2_Addr !== rt)) begin
      n_miss++; $display("FAIL read_addr: got %0d/%0d want %0d/%0d", R1_Addr, R2_Addr, rs, rt);
    end
    n_vec++;
    if (W_en !== (bp && bpa != 0)) begin
      n_miss++; $display("FAIL read_wen: got %b want %b", W_en, (bp && bpa != 0));
    end
    step();
    wb_valid = 1'b0;
    if (bp && bpa != 0) ref_regs[bpa] = bpd;
    // HOLD, possibly with backpressure
    for (int c = 0; c <= stall; c++) begin
      in_valid = 1'b1;
      out_ready = (c == stall);
      #1;
      n_vec++;
      if ({out_valid, in_ready, R1_en, R2_en} !== 4'b1000 || out_op_a !== ea ||
          out_op_b !== eb || out_rd !== rd) begin
        n_miss++; $display("FAIL hold c=%0d: got v=%b a=%h b=%h rd=%0d want v=1 a=%h b=%h rd=%0d",
                           c, out_valid, out_op_a, out_op_b, out_rd, ea, eb, rd);
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_miss++; $display("FAIL back_idle: got ov/rdy=%b want 01", {out_valid, in_ready});
    end
    $display("fetch rs=%0d rt=%0d rd=%0d use=%b%b bp=%b@%0d stall=%0d -> a=%h b=%h",
             rs, rt, rd, urs, urt, bp, bpa, stall, ea, eb);
  endtask

  task automatic test_reset();
    Rst = 1'b1; load_rf = 1'b1;
    in_valid = 1'b1; in_rs = 5'd3; in_rt = 5'd4; in_rd = 5'd1; in_use_rs = 1'b1; in_use_rt = 1'b1;
    out_ready = 1'b0; wb_valid = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFE0007;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if ({W_en, in_ready, out_valid, R1_en, R2_en} !== 5'b0 || R1_Addr !== 0 || R2_Addr !== 0 ||
          out_op_a !== 0 || out_op_b !== 0 || out_rd !== 0) begin
        n_miss++; $display("FAIL reset_cyc%0d: got wen/rdy/ov/en=%b a=%h rd=%0d want all zero",
                           i, {W_en, in_ready, out_valid, R1_en, R2_en}, out_op_a, out_rd);
      end
    end
    Rst = 1'b0; load_rf = 1'b0; in_valid = 1'b0; wb_valid = 1'b0;
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_miss++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
    $display("reset: 3 cycles with in_valid/wb_valid high");
  endtask

  task automatic test_basic();
    wb_write(5'd5, 32'h11111111);
    wb_write(5'd9, 32'h22222222);
    fetch(5'd5, 5'd9, 5'd3, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 0);
  endtask

  task automatic test_bypass();
    fetch(5'd5, 5'd5, 5'd7, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 0);
    n_vec++;
    if (rf[5] !== 32'hDEADBEEF) begin
      n_miss++; $display("FAIL bypass_commit: got %h want deadbeef", rf[5]);
    end
    fetch(5'd5, 5'd9, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 0);
  endtask

  task automatic test_zero();
    wb_write(5'd0, 32'hFFFFFFFF);
    fetch(5'd0, 5'd9, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 0);
    fetch(5'd9, 5'd12, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 0);
    fetch(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 0);
  endtask

  task automatic test_backpressure();
    fetch(5'd9, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 5);
    fetch(5'd12, 5'd9, 5'd8, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 0);
  endtask

  task automatic test_back_to_back();
    time t0;
    t0 = $time;
    for (int i = 0; i < 3; i++)
      fetch(5'(i + 1), 5'(i + 10), 5'(i), 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 0);
    n_vec++;
    if ($time - t0 !== 90) begin
      n_miss++; $display("FAIL throughput: got %0t want 90", $time - t0);
    end
  endtask

  task automatic test_reset_midop();
    in_valid = 1'b1; in_rs = 5'd5; in_rt = 5'd9; in_rd = 5'd17; in_use_rs = 1'b1; in_use_rt = 1'b1;
    step();
    in_valid = 1'b0; Rst = 1'b1;
    step();
    n_vec++;
    if ({out_valid, R1_en, R2_en, in_ready} !== 4'b0 || out_op_a !== 0 || out_rd !== 0) begin
      n_miss++; $display("FAIL midop_reset: got ov/en/rdy=%b a=%h rd=%0d want zeros",
                         {out_valid, R1_en, R2_en, in_ready}, out_op_a, out_rd);
    end
    Rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if ({out_valid, in_ready} !== 2'b01) begin
        n_miss++; $display("FAIL midop_discard c=%0d: got ov/rdy=%b want 01", i, {out_valid, in_ready});
      end
      step();
    end
    $display("reset mid-op: request rd=17 discarded");
  endtask

  task automatic test_random();
    logic [AW-1:0] rs, rt, a;
    logic bp;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(2, 0) == 0) wb_write(5'($urandom), $urandom);
      rs = 5'($urandom); rt = 5'($urandom);
      bp = 1'($urandom);
      case ($urandom_range(3, 0))
        0: a = rs;
        1: a = rt;
        2: a = 5'd0;
        default: a = 5'($urandom);
      endcase
      fetch(rs, rt, 5'($urandom), 1'($urandom), 1'($urandom), bp, a, $urandom,
            int'($urandom_range(3, 0)));
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      seed[i] = $urandom;
      ref_regs[i] = seed[i];
    end
    seed[0] = 32'hBAD0BAD0;
    test_reset();
    test_basic();
    test_bypass();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
endmodule
